// File: rtl/fifo_reader_pkg.sv
// rtl/fifo_reader_pkg.sv - shared constants and types for the fifo_reader block
// Purpose: occupancy state encoding of the 2-entry output buffer and the
//          default data width shared by fifo_reader and fifo_reader_buf.
// Ports:   none (package).
package fifo_reader_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/fifo_reader_buf.sv
// rtl/fifo_reader_buf.sv - 2-entry in-order output buffer with occupancy FSM
// Purpose: holds up to two words fetched from the FIFO and presents the head
//          entry as a registered valid/ready output stream.
// Ports:   clk, rst       - clock, synchronous active-high reset
//          flush          - discard both entries
//          push/push_data - write a word into the tail entry
//          ready          - downstream accepts the head word
//          valid/data     - head word of the output stream (data is 0 when empty)
//          full           - both entries occupied (no push allowed)
//          pop            - head word transferred this cycle
module fifo_reader_buf
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  full,
    output logic                  pop
);

    occ_state_t            state, state_next;
    logic [DATA_WIDTH-1:0] head, head_next;
    logic [DATA_WIDTH-1:0] tail, tail_next;

    assign valid = (state != ST_EMPTY);
    assign full  = (state == ST_TWO);
    assign pop   = valid & ready;
    assign data  = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_next;
            head  <= head_next;
            tail  <= tail_next;
        end
    end

    // Entries are cleared whenever they become unoccupied so the head
    // register alone drives a zero output while the buffer is empty.
    always_comb begin
        state_next = state;
        head_next  = head;
        tail_next  = tail;
        if (flush) begin
            state_next = ST_EMPTY;
            head_next  = '0;
            tail_next  = '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        state_next = ST_ONE;
                        head_next  = push_data;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_next = push_data;
                    end else if (push) begin
                        state_next = ST_TWO;
                        tail_next  = push_data;
                    end else if (pop) begin
                        state_next = ST_EMPTY;
                        head_next  = '0;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_next = ST_ONE;
                        head_next  = tail;
                        tail_next  = '0;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                    head_next  = '0;
                    tail_next  = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FIFO read-side fetcher feeding a valid/ready stream
// Purpose: pulls words from a FIFO into a 2-entry buffer, streams them out,
//          and counts completed output transfers.
// Ports:   clk, rst                 - clock, synchronous active-high reset
//          fifo_empty, fifo_data_rd - FIFO read side status and data
//          fifo_rd_en               - FIFO read strobe (one word per high cycle)
//          enable                   - permits fetching
//          flush                    - discards buffered words
//          m_valid, m_data, m_ready - output stream
//          xfer_count               - completed output transfers (wraps)
//          busy                     - words buffered or a fetch in progress
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_rd,
    output logic                  fifo_rd_en,
    input  logic                  enable,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  xfer_count,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic buf_full;
    logic pop;

    // Fetch gating deliberately ignores m_ready: a slot is free whenever the
    // buffer is not full, which is what sustains 1 word/cycle in state ONE.
    assign fifo_rd_en = enable & ~fifo_empty & ~flush & ~rst & ~buf_full;

    fifo_reader_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (fifo_rd_en),
        .push_data (fifo_data_rd),
        .ready     (m_ready),
        .valid     (m_valid),
        .data      (m_data),
        .full      (buf_full),
        .pop       (pop)
    );

    // A pop in the same cycle as a flush is a completed transfer and counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count <= '0;
        end else if (pop) begin
            xfer_count <= xfer_count + CNT_ONE;
        end
    end

    assign busy = m_valid | fifo_rd_en;

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - self-checking bench for fifo_reader
module tb_fifo_reader;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data_rd;
    logic          fifo_rd_en;
    logic          enable;
    logic          flush;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [CW-1:0] xfer_count;
    logic          busy;

    always #5 clk = ~clk;

    fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_data_rd (fifo_data_rd),
        .fifo_rd_en   (fifo_rd_en),
        .enable       (enable),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .xfer_count   (xfer_count),
        .busy         (busy)
    );

    // Source FIFO model: data is presented only while the read strobe is high.
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] src_head;
    logic          src_hold;
    assign fifo_data_rd = fifo_rd_en ? src_head : '0;

    // Reference model: in-order buffer of at most two words plus a transfer count.
    logic [DW-1:0] buf_q[$];
    int            exp_cnt;
    bit            known;
    int            dut_rd_pulses;
    int            checks;
    int            failures;
    int            cnt_mark;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit exp_rd;
        fifo_empty = (src_q.size() == 0) || src_hold;
        src_head   = (src_q.size() != 0) ? src_q[0] : '0;
        #1;
        exp_rd = enable && !fifo_empty && !flush && !rst && (buf_q.size() < 2);
        check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        if (known) begin
            check("m_valid", 32'(m_valid), 32'(buf_q.size() != 0));
            check("m_data", 32'(m_data), (buf_q.size() != 0) ? 32'(buf_q[0]) : 32'd0);
            check("busy", 32'(busy), 32'((buf_q.size() != 0) || exp_rd));
            check("xfer_count", 32'(xfer_count), 32'(exp_cnt));
        end
        if (fifo_rd_en) dut_rd_pulses++;
        @(posedge clk);
        if (rst) begin
            buf_q.delete();
            exp_cnt = 0;
            known   = 1'b1;
        end else begin
            if (buf_q.size() != 0 && m_ready) begin
                void'(buf_q.pop_front());
                exp_cnt = (exp_cnt + 1) % (1 << CW);
            end
            if (flush) buf_q.delete();
            else if (exp_rd) buf_q.push_back(src_q.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0; exp_cnt = 0; known = 1'b0; dut_rd_pulses = 0;
        rst = 1'b1; enable = 1'b1; flush = 1'b0; m_ready = 1'b0; src_hold = 1'b0;
        src_q = '{8'h5A, 8'h6B};
        @(negedge clk);

        // Reset with a non-empty FIFO and enable high: no reads.
        step(); step();
        rst = 1'b0; enable = 1'b0;
        step(); step();
        check("reset_count", 32'(xfer_count), 32'd0);
        src_q.delete();

        // Streaming at one word per cycle.
        src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        enable = 1'b1; m_ready = 1'b1;
        cnt_mark = int'(xfer_count);
        repeat (7) step();
        check("stream_count", 32'(xfer_count), 32'((cnt_mark + 4) % 16));

        // Backpressure: only two fetches, head held.
        m_ready = 1'b0; dut_rd_pulses = 0;
        src_q = '{8'hC1, 8'hC2, 8'hC3};
        cnt_mark = int'(xfer_count);
        repeat (5) step();
        check("bp_rd_pulses", 32'(dut_rd_pulses), 32'd2);
        check("bp_head", 32'(m_data), 32'h0C1);
        m_ready = 1'b1;
        repeat (5) step();
        check("bp_count", 32'(xfer_count), 32'((cnt_mark + 3) % 16));

        // Flush while holding two words.
        m_ready = 1'b0;
        src_q = '{8'hA1, 8'hA2};
        cnt_mark = int'(xfer_count);
        repeat (3) step();
        flush = 1'b1; step(); flush = 1'b0;
        m_ready = 1'b1;
        repeat (3) step();
        check("flush_count", 32'(xfer_count), 32'(cnt_mark));

        // Enable drop with FIFO still non-empty.
        m_ready = 1'b0;
        src_q = '{8'hB1, 8'hB2, 8'hB3};
        step();
        enable = 1'b0;
        step();
        m_ready = 1'b1;
        repeat (2) step();
        check("drop_busy", 32'(busy), 32'd0);
        src_q.delete();

        // Randomized traffic with empty-flag glitches, flushes and resets.
        for (int i = 0; i < 1500; i++) begin
            enable   = ($urandom_range(0, 3) != 0);
            m_ready  = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 31) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            src_hold = ($urandom_range(0, 3) == 0);
            if (src_q.size() < 4 && $urandom_range(0, 1) == 1)
                src_q.push_back(DW'($urandom));
            step();
        end

        // Counter wrap: 17 transfers after reset on a 4-bit counter.
        rst = 1'b1; flush = 1'b0; src_hold = 1'b0; enable = 1'b0; src_q.delete();
        step();
        rst = 1'b0; enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 17; i++) src_q.push_back(DW'(i + 1));
        repeat (20) step();
        check("wrap_count", 32'(xfer_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
